// File: rtl/jacob_to_affine_conv_if.sv
// Bundles the request/response signals of the Jacobian-to-affine converter.
//
// Handshake: the master raises start for one cycle with x3/y3/z3/p valid in
// that same cycle. The converter accepts it only while idle. busy is high from
// the cycle after acceptance through the done cycle. done is a one-cycle pulse,
// and x/y/inf are valid with it and held until the next done. A start that
// arrives while the converter is not idle is dropped, not queued.
//
// Signals:
//   start             request pulse (master -> converter)
//   x3, y3, z3, p     Jacobian point and odd prime modulus, sampled on accept
//   x, y, inf         affine result and point-at-infinity flag
//   busy, done        operation in flight / completion pulse
//   dbg_state         current FSM state encoding, for observation only
interface jacob_to_affine_conv_if #(
  parameter int WIDTH = 256
);
  logic             start;
  logic [WIDTH-1:0] x3;
  logic [WIDTH-1:0] y3;
  logic [WIDTH-1:0] z3;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             inf;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state;

  modport master (
    output start, x3, y3, z3, p,
    input  x, y, inf, busy, done, dbg_state
  );

  modport slave (
    input  start, x3, y3, z3, p,
    output x, y, inf, busy, done, dbg_state
  );
endinterface

// File: rtl/jacob_to_affine_conv.sv
// Jacobian (X3,Y3,Z3) to affine (x,y) converter over GF(p):
//   x = X3 / Z3^2 mod p,  y = Y3 / Z3^3 mod p.
// One binary extended-Euclid inverter (one step per cycle) feeds one shared
// interleaved shift-add modular multiplier (one bit per cycle).
//
// Build option: define Y_OUT_EN to include the y path (t3 = zi^3 and the
// Y multiply). Without it y is constant 0 and only two multiplies are run.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset; aborts any operation
//   bus   jacob_to_affine_conv_if.slave (start, x3, y3, z3, p, x, y, inf,
//         busy, done, dbg_state)
module jacob_to_affine_conv #(
  parameter int WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  jacob_to_affine_conv_if.slave bus
);

  // Counter wide enough for the inverter watchdog (4*WIDTH+4 cycles) and for
  // the multiplier bit index.
  localparam int CW = $clog2(4 * WIDTH + 5);
  localparam logic [CW-1:0] WD_LAST  = CW'(4 * WIDTH + 3);
  localparam logic [CW-1:0] BIT_HIGH = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INV  = 3'd1,
    MZ2  = 3'd2,
    MZ3  = 3'd3,
    MX   = 3'd4,
    MY   = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] x_q, p_q;
  logic [WIDTH-1:0] u, v, a, b;
  logic [WIDTH-1:0] zi, t2;
  logic [WIDTH-1:0] x_r;
  logic             inf_r;
  logic [WIDTH+1:0] r;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] x_o;
  logic             inf_o, busy_o, done_o;

`ifdef Y_OUT_EN
  logic [WIDTH-1:0] y_q, t3, y_r, y_o;
`endif

  // ---------------- inverter step helpers ----------------
  logic             u_is1, v_is1, u_ge_v, inv_timeout, inv_fin;
  logic [WIDTH:0]   a_sum, b_sum;
  logic [WIDTH-1:0] a_half, b_half;
  logic [WIDTH:0]   ab_diff, ba_diff;
  logic [WIDTH-1:0] a_sub, b_sub;

  assign u_is1       = (u == WIDTH'(1));
  assign v_is1       = (v == WIDTH'(1));
  assign u_ge_v      = (u >= v);
  assign inv_timeout = (cnt == WD_LAST);
  assign inv_fin     = u_is1 | v_is1 | inv_timeout;

  // Halving mod p: an odd value becomes even after adding the odd modulus,
  // so the sum needs one extra bit before the shift.
  assign a_sum  = {1'b0, a} + (a[0] ? {1'b0, p_q} : '0);
  assign b_sum  = {1'b0, b} + (b[0] ? {1'b0, p_q} : '0);
  assign a_half = WIDTH'(a_sum >> 1);
  assign b_half = WIDTH'(b_sum >> 1);

  // Subtraction mod p: the top bit of the extended difference is the borrow;
  // adding p back wraps modulo 2^WIDTH to the correct residue.
  assign ab_diff = {1'b0, a} - {1'b0, b};
  assign ba_diff = {1'b0, b} - {1'b0, a};
  assign a_sub   = ab_diff[WIDTH] ? (ab_diff[WIDTH-1:0] + p_q) : ab_diff[WIDTH-1:0];
  assign b_sub   = ba_diff[WIDTH] ? (ba_diff[WIDTH-1:0] + p_q) : ba_diff[WIDTH-1:0];

  // ---------------- shared multiplier ----------------
  logic [WIDTH-1:0] mul_a, mul_b, mul_b_sh;
  logic [WIDTH+1:0] p_ext, rd0, rd1, rd2, rd3;
  logic             mul_bit, in_mult, mul_last;
  logic [WIDTH-1:0] prod;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MZ2: begin mul_a = zi;  mul_b = zi; end
`ifdef Y_OUT_EN
      MZ3: begin mul_a = t2;  mul_b = zi; end
      MY:  begin mul_a = y_q; mul_b = t3; end
`endif
      MX:  begin mul_a = x_q; mul_b = t2; end
      default: ;
    endcase
  end

  assign in_mult  = (state_q == MZ2) || (state_q == MZ3) ||
                    (state_q == MX)  || (state_q == MY);
  assign mul_last = (cnt == '0);
  assign mul_b_sh = mul_b >> cnt;
  assign mul_bit  = mul_b_sh[0];
  assign p_ext    = {2'b00, p_q};
  assign rd0      = r << 1;
  assign rd1      = (rd0 >= p_ext) ? (rd0 - p_ext) : rd0;
  assign rd2      = mul_bit ? (rd1 + {2'b00, mul_a}) : rd1;
  assign rd3      = (rd2 >= p_ext) ? (rd2 - p_ext) : rd2;
  assign prod     = WIDTH'(rd3);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (bus.z3 == '0) ? DONE : INV;
      INV:  if (inv_fin) state_d = MZ2;
`ifdef Y_OUT_EN
      MZ2:  if (mul_last) state_d = MZ3;
      MZ3:  if (mul_last) state_d = MX;
      MX:   if (mul_last) state_d = MY;
      MY:   if (mul_last) state_d = DONE;
`else
      MZ2:  if (mul_last) state_d = MX;
      MX:   if (mul_last) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      p_q    <= '0;
      u      <= '0;
      v      <= '0;
      a      <= '0;
      b      <= '0;
      zi     <= '0;
      t2     <= '0;
      x_r    <= '0;
      inf_r  <= 1'b0;
      r      <= '0;
      cnt    <= '0;
      x_o    <= '0;
      inf_o  <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
`ifdef Y_OUT_EN
      y_q    <= '0;
      t3     <= '0;
      y_r    <= '0;
      y_o    <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      // In IDLE busy follows the accept; everywhere else an op is in flight,
      // including DONE, which keeps busy high through the done cycle.
      busy_o <= (state_q == IDLE) ? bus.start : 1'b1;

      if (in_mult) begin
        r   <= mul_last ? '0 : rd3;
        cnt <= mul_last ? BIT_HIGH : (cnt - CW'(1));
      end

      case (state_q)
        IDLE: if (bus.start) begin
          x_q   <= bus.x3;
          p_q   <= bus.p;
          u     <= bus.z3;
          v     <= bus.p;
          a     <= WIDTH'(1);
          b     <= '0;
          cnt   <= '0;
          r     <= '0;
          x_r   <= '0;
          inf_r <= (bus.z3 == '0);
`ifdef Y_OUT_EN
          y_q   <= bus.y3;
          y_r   <= '0;
`endif
        end
        INV: begin
          if (u_is1 || v_is1) begin
            zi  <= u_is1 ? a : b;
            cnt <= BIT_HIGH;
          end else if (inv_timeout) begin
            // Only reachable for an even modulus or out-of-range inputs.
            zi  <= '0;
            cnt <= BIT_HIGH;
          end else begin
            cnt <= cnt + CW'(1);
            if (!u[0]) begin
              u <= u >> 1;
              a <= a_half;
            end else if (!v[0]) begin
              v <= v >> 1;
              b <= b_half;
            end else if (u_ge_v) begin
              u <= u - v;
              a <= a_sub;
            end else begin
              v <= v - u;
              b <= b_sub;
            end
          end
        end
        MZ2: if (mul_last) t2 <= prod;
`ifdef Y_OUT_EN
        MZ3: if (mul_last) t3 <= prod;
        MY:  if (mul_last) y_r <= prod;
`endif
        MX:  if (mul_last) x_r <= prod;
        DONE: begin
          x_o    <= x_r;
          inf_o  <= inf_r;
          done_o <= 1'b1;
`ifdef Y_OUT_EN
          y_o    <= y_r;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.x         = x_o;
  assign bus.inf       = inf_o;
  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.dbg_state = state_q;
`ifdef Y_OUT_EN
  assign bus.y         = y_o;
`else
  assign bus.y         = '0;
`endif

endmodule
